mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle control unit that consumes the fetched 32-bit instruction word and drives the PC unit's next-PC select (pc_s) and write strobe.
//  Also drives the register-file, ALU and data-memory strobes.
//  Owns the instruction register (IR). Advances on posedge clk; the PC unit samples pc_s/pc_write on the following negedge.
// PARAMETERS
//  INST_W      32  instruction word width
//  ALU_OP_W    4   ALU operation code width
//  PERF_CNT_W  32  width of performance counters (CTRL_PERF_CNT_EN only)
// PORTS
//  clk         in   1          system clock, posedge
//  rst         in   1          reset, asynchronous, active-high
//  inst_code   in   INST_W     instruction word from instruction ROM
//  zf          in   1          ALU zero flag, valid in BR state
//  ir          out  INST_W     latched instruction register
//  pc_write    out  1          PC update strobe (last cycle of every instruction)
//  pc_s        out  2          00 PC+4, 01 rs (jr), 10 PC+4+(imm<<2), 11 {PC+4[31:28],addr,00}
//  ir_write    out  1          IR load strobe (IF state)
//  reg_write   out  1          register-file write enable
//  w_r_s       out  2          dest reg select: 00 rd, 01 rt, 10 $31
//  wr_data_s   out  2          write-back source: 00 ALU, 01 mem, 10 PC+4
//  alu_src_b   out  1          0 rt, 1 extended immediate
//  imm_s       out  1          1 sign-extend, 0 zero-extend immediate
//  alu_op      out  ALU_OP_W   ALU function code (package constants)
//  mem_write   out  1          data-memory write enable
//  state       out  4          current FSM state (debug)
//  illegal     out  1          1-cycle pulse: undecodable opcode/funct retired as NOP
//  cyc_cnt     out  PERF_CNT_W cycle count (0 when CTRL_PERF_CNT_EN absent)
//  ret_cnt     out  PERF_CNT_W retired instructions (0 when CTRL_PERF_CNT_EN absent)
// BEHAVIOUR
//  Reset: state=IF, ir=0, all strobes 0, pc_s=00, alu_op=ADD. Async; strobes drop in the same cycle. Reset mid-instruction abandons the instruction without partial writes.
//  Outputs are Moore decodes of state+ir. The exception is pc_s in BR, which depends on zf.
//  IF:     ir_write=1; ir<=inst_code at posedge -> ID.
//  ID:     j   -> pc_write, pc_s=11 -> IF.  jr -> pc_write, pc_s=01 -> IF.
//          jal -> JAL.  beq/bne -> BR.  lw/sw -> ADDR.  R/I ALU -> EXE.
//          Illegal -> illegal=1, pc_write, pc_s=00 -> IF.
//  EXE:    alu_op from funct/opcode. alu_src_b=1 for I-type. imm_s=0 for andi/ori/xori/lui -> WB.
//  WB:     reg_write=1; w_r_s=00 (R) or 01 (I); pc_write, pc_s=00 -> IF.
//  ADDR:   alu_op=ADD, alu_src_b=1, imm_s=1 -> MEMRD (lw) or MEMWR (sw).
//  MEMRD -> LDWB: reg_write, w_r_s=01, wr_data_s=01, pc_write, pc_s=00 -> IF.
//  MEMWR:  mem_write=1, pc_write, pc_s=00 -> IF.
//  BR:     alu_op=SUB. Taken if (beq&zf)|(bne&~zf) -> pc_s=10, else pc_s=00. pc_write=1 -> IF.
//  JAL:    reg_write, w_r_s=10, wr_data_s=10, pc_write, pc_s=11 -> IF.
//  Latency in cycles from IF: j/jr/illegal 2; beq/bne/jal 3; ALU/sw 4; lw 5.
//  Exactly one pc_write per instruction; never asserted in IF. Unused state codes -> IF.
//  Supported: R add addu sub subu and or xor nor slt sltu sllv srlv srav jr; I addi addiu andi ori xori slti sltiu lui; lw sw beq bne j jal.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: cyc_cnt increments every non-reset cycle; ret_cnt increments on every pc_write. Both wrap modulo 2^PERF_CNT_W and clear on rst.
//  Not defined: no counter flops; cyc_cnt and ret_cnt are tied to 0.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode/funct constants, state encoding, ALU_OP codes, PC_S codes, W_R_S and WR_DATA_S codes.
//  Sub-module mips_inst_dec (combinational): ir -> instruction class, alu_op, imm_s, illegal.
//  The FSM and IR live in this file.
// TESTING
//  rst mid-EXE of add -> strobes 0 immediately; next IF refetches; no reg_write seen.
//  add $3,$1,$2 (0x00221820) -> 4 cycles; WB: reg_write=1, w_r_s=00, pc_s=00.
//  beq with zf=1 -> BR: pc_s=10, pc_write=1; repeat with zf=0 -> pc_s=00. bne gives the inverse.
//  lw 0x8C220004 -> 5 cycles, ADDR imm_s=1, LDWB wr_data_s=01; sw 0xAC220004 -> mem_write in MEMWR only.
//  jal 0x0C000010 -> JAL: w_r_s=10, wr_data_s=10, pc_s=11; jr $31 (0x03E00008) -> pc_s=01 in ID.
//  opcode 0x3F -> illegal 1-cycle pulse in ID; pc_s=00; ret_cnt+1 with CTRL_PERF_CNT_EN.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control unit:
//            opcode/funct values, FSM state codes, ALU operation codes,
//            PC-select, destination-register and write-back source codes,
//            and the decoded instruction class.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // FSM state encoding
    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_EXE   = 4'd2;
    localparam logic [3:0] S_WB    = 4'd3;
    localparam logic [3:0] S_ADDR  = 4'd4;
    localparam logic [3:0] S_MEMRD = 4'd5;
    localparam logic [3:0] S_LDWB  = 4'd6;
    localparam logic [3:0] S_MEMWR = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JAL   = 4'd9;

    // ALU function codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // Next-PC select
    localparam logic [1:0] PC_S_PC4  = 2'b00;
    localparam logic [1:0] PC_S_RS   = 2'b01;
    localparam logic [1:0] PC_S_BR   = 2'b10;
    localparam logic [1:0] PC_S_JUMP = 2'b11;

    // Destination register select
    localparam logic [1:0] W_R_S_RD = 2'b00;
    localparam logic [1:0] W_R_S_RT = 2'b01;
    localparam logic [1:0] W_R_S_RA = 2'b10;

    // Write-back data source
    localparam logic [1:0] WR_DATA_S_ALU = 2'b00;
    localparam logic [1:0] WR_DATA_S_MEM = 2'b01;
    localparam logic [1:0] WR_DATA_S_PC4 = 2'b10;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JR,
        CLS_JAL,
        CLS_ILLEGAL
    } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : mips_inst_dec
// Purpose  : Combinational instruction decoder. Maps opcode/funct to an
//            instruction class, ALU function, immediate extension mode and
//            an illegal flag.
// Ports    : opcode_i  ir[31:26]
//            funct_i   ir[5:0]
//            cls_o     decoded instruction class
//            alu_op_o  ALU function for the execute step
//            imm_s_o   1 sign-extend, 0 zero-extend
//            illegal_o opcode/funct not supported
// Revision : 1.0 - initial release
// ============================================================================
module mips_inst_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    output inst_class_t cls_o,
    output logic [3:0]  alu_op_o,
    output logic        imm_s_o,
    output logic        illegal_o
);

    always_comb begin
        cls_o    = CLS_ILLEGAL;
        alu_op_o = ALU_ADD;
        imm_s_o  = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                cls_o = CLS_ALU_R;
                case (funct_i)
                    F_ADD, F_ADDU: alu_op_o = ALU_ADD;
                    F_SUB, F_SUBU: alu_op_o = ALU_SUB;
                    F_AND:         alu_op_o = ALU_AND;
                    F_OR:          alu_op_o = ALU_OR;
                    F_XOR:         alu_op_o = ALU_XOR;
                    F_NOR:         alu_op_o = ALU_NOR;
                    F_SLT:         alu_op_o = ALU_SLT;
                    F_SLTU:        alu_op_o = ALU_SLTU;
                    F_SLLV:        alu_op_o = ALU_SLL;
                    F_SRLV:        alu_op_o = ALU_SRL;
                    F_SRAV:        alu_op_o = ALU_SRA;
                    F_JR:          cls_o    = CLS_JR;
                    default:       cls_o    = CLS_ILLEGAL;
                endcase
            end
            OP_J:     cls_o = CLS_J;
            OP_JAL:   cls_o = CLS_JAL;
            // Branch compare is a subtract; the ALU zero flag decides.
            OP_BEQ:   begin cls_o = CLS_BEQ; alu_op_o = ALU_SUB; end
            OP_BNE:   begin cls_o = CLS_BNE; alu_op_o = ALU_SUB; end
            OP_ADDI,
            OP_ADDIU: cls_o = CLS_ALU_I;
            OP_SLTI:  begin cls_o = CLS_ALU_I; alu_op_o = ALU_SLT;  end
            OP_SLTIU: begin cls_o = CLS_ALU_I; alu_op_o = ALU_SLTU; end
            // Logical immediates and lui take the immediate zero-extended.
            OP_ANDI:  begin cls_o = CLS_ALU_I; alu_op_o = ALU_AND; imm_s_o = 1'b0; end
            OP_ORI:   begin cls_o = CLS_ALU_I; alu_op_o = ALU_OR;  imm_s_o = 1'b0; end
            OP_XORI:  begin cls_o = CLS_ALU_I; alu_op_o = ALU_XOR; imm_s_o = 1'b0; end
            OP_LUI:   begin cls_o = CLS_ALU_I; alu_op_o = ALU_LUI; imm_s_o = 1'b0; end
            OP_LW:    cls_o = CLS_LW;
            OP_SW:    cls_o = CLS_SW;
            default:  cls_o = CLS_ILLEGAL;
        endcase
        illegal_o = (cls_o == CLS_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multi-cycle MIPS control unit. Owns the instruction register
//            and the sequencing FSM; drives PC, register-file, ALU and
//            data-memory control. Outputs are Moore decodes of state + IR,
//            except pc_s in BR which follows zf.
// Ports    : clk, rst (async, active-high), inst_code, zf in;
//            ir, pc_write, pc_s, ir_write, reg_write, w_r_s, wr_data_s,
//            alu_src_b, imm_s, alu_op, mem_write, state, illegal,
//            cyc_cnt, ret_cnt out.
// Config   : CTRL_PERF_CNT_EN - when defined, cyc_cnt/ret_cnt are live
//            counters; otherwise they are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int INST_W     = 32,
    parameter int ALU_OP_W   = 4,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_W-1:0]     inst_code,
    input  logic                  zf,
    output logic [INST_W-1:0]     ir,
    output logic                  pc_write,
    output logic [1:0]            pc_s,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            w_r_s,
    output logic [1:0]            wr_data_s,
    output logic                  alu_src_b,
    output logic                  imm_s,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  mem_write,
    output logic [3:0]            state,
    output logic                  illegal,
    output logic [PERF_CNT_W-1:0] cyc_cnt,
    output logic [PERF_CNT_W-1:0] ret_cnt
);

    logic [3:0]        state_q, state_d;
    logic [INST_W-1:0] ir_q;
    inst_class_t       dec_cls;
    logic [3:0]        dec_alu_op;
    logic              dec_imm_s;
    logic              dec_illegal;
    logic [3:0]        alu_op_c;

    mips_inst_dec u_dec (
        .opcode_i  (ir_q[INST_W-1 -: 6]),
        .funct_i   (ir_q[5:0]),
        .cls_o     (dec_cls),
        .alu_op_o  (dec_alu_op),
        .imm_s_o   (dec_imm_s),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF) ir_q <= inst_code;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
                case (dec_cls)
                    CLS_ALU_R, CLS_ALU_I: state_d = S_EXE;
                    CLS_LW, CLS_SW:       state_d = S_ADDR;
                    CLS_BEQ, CLS_BNE:     state_d = S_BR;
                    CLS_JAL:              state_d = S_JAL;
                    default:              state_d = S_IF;  // j, jr, illegal
                endcase
            end
            S_EXE:   state_d = S_WB;
            S_ADDR:  state_d = (dec_cls == CLS_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: state_d = S_LDWB;
            default: state_d = S_IF;  // last-cycle states and unused codes
        endcase
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_s      = PC_S_PC4;
        reg_write = 1'b0;
        w_r_s     = W_R_S_RD;
        wr_data_s = WR_DATA_S_ALU;
        alu_src_b = 1'b0;
        imm_s     = 1'b0;
        alu_op_c  = ALU_ADD;
        mem_write = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IF: ir_write = 1'b1;
            S_ID: begin
                if (dec_cls == CLS_J) begin
                    pc_write = 1'b1;
                    pc_s     = PC_S_JUMP;
                end else if (dec_cls == CLS_JR) begin
                    pc_write = 1'b1;
                    pc_s     = PC_S_RS;
                end else if (dec_illegal) begin
                    // Undecodable word retires as a NOP.
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXE, S_WB: begin
                // ALU controls are held through WB so an unregistered ALU
                // result stays stable while it is written back.
                alu_op_c  = dec_alu_op;
                alu_src_b = (dec_cls == CLS_ALU_I);
                imm_s     = dec_imm_s;
                if (state_q == S_WB) begin
                    reg_write = 1'b1;
                    w_r_s     = (dec_cls == CLS_ALU_I) ? W_R_S_RT : W_R_S_RD;
                    pc_write  = 1'b1;
                end
            end
            S_ADDR: begin
                alu_src_b = 1'b1;
                imm_s     = 1'b1;
            end
            S_LDWB: begin
                reg_write = 1'b1;
                w_r_s     = W_R_S_RT;
                wr_data_s = WR_DATA_S_MEM;
                pc_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                pc_write  = 1'b1;
            end
            S_BR: begin
                alu_op_c = ALU_SUB;
                pc_write = 1'b1;
                if (((dec_cls == CLS_BEQ) && zf) || ((dec_cls == CLS_BNE) && !zf))
                    pc_s = PC_S_BR;
            end
            S_JAL: begin
                reg_write = 1'b1;
                w_r_s     = W_R_S_RA;
                wr_data_s = WR_DATA_S_PC4;
                pc_write  = 1'b1;
                pc_s      = PC_S_JUMP;
            end
            default: ;
        endcase
        // Reset state is IF, but no strobe may fire while reset is held.
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_s      = PC_S_PC4;
            reg_write = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
            alu_op_c  = ALU_ADD;
        end
    end

    assign alu_op = ALU_OP_W'(alu_op_c);
    assign ir     = ir_q;
    assign state  = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] cyc_cnt_q, ret_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
            if (pc_write) ret_cnt_q <= ret_cnt_q + 1'b1;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif

endmodule
`default_nettype wire
